// File: rtl/fetch_decode_queue.sv
// IF->ID boundary queue: DEPTH-entry circular buffer of (pc, inst, excepttype) with
// valid/ready on both sides and single-cycle flush. Define IFQ_BYPASS_EN for zero-latency empty-queue bypass.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int EW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [AW-1:0]            if_pc,
  input  logic [DW-1:0]            if_inst,
  input  logic [EW-1:0]            if_excepttype,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [AW-1:0]            id_pc,
  output logic [DW-1:0]            id_inst,
  output logic [EW-1:0]            id_excepttype,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];
  logic [EW-1:0] exc_mem  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic stored;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  assign stored   = (count != '0);
  assign if_ready = (count != FULL) & ~flush;

`ifdef IFQ_BYPASS_EN
  // An entry arriving at an empty queue is shown to ID in the same cycle.
  assign bypass = ~stored & if_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = stored | bypass;
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  // A bypassed entry that ID takes immediately never touches storage.
  assign wr_en = push & ~(bypass & id_ready);
  assign rd_en = pop & stored;

  // Head of queue, or zero bubble when nothing is available.
  always_comb begin
    id_pc         = '0;
    id_inst       = '0;
    id_excepttype = '0;
    if (stored) begin
      id_pc         = pc_mem[rd_ptr];
      id_inst       = inst_mem[rd_ptr];
      id_excepttype = exc_mem[rd_ptr];
    end else if (bypass) begin
      id_pc         = if_pc;
      id_inst       = if_inst;
      id_excepttype = if_excepttype;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
      exc_mem[wr_ptr]  <= if_excepttype;
    end
  end

  // Control state: flush clears exactly like reset and overrides any push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (default build, DEPTH=4, no bypass).
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic [EW-1:0] if_excepttype;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic [EW-1:0] id_excepttype;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .EW(EW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_inst(if_inst), .if_excepttype(if_excepttype),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_inst(id_inst), .id_excepttype(id_excepttype), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1 reset with if_valid held high
    rst = 1'b1; flush = 1'b0; if_valid = 1'b1; id_ready = 1'b0;
    if_pc = 32'h50; if_inst = 32'hDEAD_BEEF; if_excepttype = 32'h1;
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    rst = 1'b0; if_valid = 1'b0;
    settle();
    check("rst_if_ready", 64'(if_ready), 64'd1);
    check("rst_id_valid2", 64'(id_valid), 64'd0);
    check("rst_id_pc", 64'(id_pc), 64'd0);
    check("rst_id_inst", 64'(id_inst), 64'd0);
    check("rst_id_exc", 64'(id_excepttype), 64'd0);
    check("rst_count2", 64'(count), 64'd0);

    // T2 fill with ID stalled, then drain
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_pc = 32'h100 + 32'(4 * i); if_inst = 32'hA0 + 32'(i); if_excepttype = '0;
      tick();
    end
    check("fill_count", 64'(count), 64'd4);
    check("fill_if_ready", 64'(if_ready), 64'd0);
    check("fill_head", 64'(id_pc), 64'h100);
    if_pc = 32'h110; if_inst = 32'hFF;
    tick();
    check("fill_5th_refused", 64'(count), 64'd4);
    if_valid = 1'b0; id_ready = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(id_valid), 64'd1);
      check("drain_pc", 64'(id_pc), 64'(32'h100 + 32'(4 * i)));
      check("drain_inst", 64'(id_inst), 64'(32'hA0 + 32'(i)));
      tick();
    end
    check("drain_empty_valid", 64'(id_valid), 64'd0);
    check("drain_empty_pc", 64'(id_pc), 64'd0);
    check("drain_empty_count", 64'(count), 64'd0);

    // T3 streaming across pointer wrap
    if_valid = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if_pc = 32'(4 * i); if_inst = 32'h1000 + 32'(i);
      settle();
      if (i == 0) begin
        check("stream_first_valid", 64'(id_valid), 64'd0);
      end else begin
        check("stream_count", 64'(count), 64'd1);
        check("stream_pc", 64'(id_pc), 64'(32'(4 * (i - 1))));
        check("stream_inst", 64'(id_inst), 64'(32'h1000 + 32'(i - 1)));
      end
      tick();
    end
    if_valid = 1'b0;
    settle();
    check("stream_last_pc", 64'(id_pc), 64'd76);
    tick();
    check("stream_end_count", 64'(count), 64'd0);

    // T4 flush with concurrent push and pop
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_pc = 32'h180 + 32'(4 * i); if_inst = 32'(i);
      tick();
    end
    check("flush_pre_count", 64'(count), 64'd3);
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h18C; id_ready = 1'b1;
    settle();
    check("flush_if_ready", 64'(if_ready), 64'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    settle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    check("flush_id_pc", 64'(id_pc), 64'd0);
    check("flush_id_inst", 64'(id_inst), 64'd0);
    if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h77;
    tick();
    if_valid = 1'b0;
    settle();
    check("flush_next_pc", 64'(id_pc), 64'h200);
    check("flush_next_count", 64'(count), 64'd1);
    id_ready = 1'b1;
    tick();
    check("flush_drain_count", 64'(count), 64'd0);

    // T5 full queue: pop frees a slot only for the following cycle
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_pc = 32'h400 + 32'(4 * i); if_inst = 32'(i);
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    if_valid = 1'b1; if_pc = 32'h410; id_ready = 1'b1;
    settle();
    check("full_if_ready", 64'(if_ready), 64'd0);
    check("full_head", 64'(id_pc), 64'h400);
    tick();
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_if_ready", 64'(if_ready), 64'd1);
    check("full_pop_head", 64'(id_pc), 64'h404);
    id_ready = 1'b0;
    tick();
    check("full_repush_count", 64'(count), 64'd4);
    if_valid = 1'b0; id_ready = 1'b1;
    settle();
    for (int i = 1; i < 5; i++) begin
      check("full_drain_pc", 64'(id_pc), 64'(32'h400 + 32'(4 * i)));
      tick();
    end
    check("full_drain_count", 64'(count), 64'd0);

    // T6 exception flags travel with their pc
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'h13; if_excepttype = 32'h0000_0200;
    tick();
    if_pc = 32'h304; if_inst = 32'h14; if_excepttype = '0;
    tick();
    if_valid = 1'b0;
    settle();
    check("exc_pc", 64'(id_pc), 64'h300);
    check("exc_flags", 64'(id_excepttype), 64'h200);
    id_ready = 1'b1;
    tick();
    check("exc_next_pc", 64'(id_pc), 64'h304);
    check("exc_next_flags", 64'(id_excepttype), 64'h0);
    tick();
    check("exc_end_count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
